// File: rtl/bbc_kb_pkg.sv
// Shared constants, FSM state type and PS/2 set-2 to BBC matrix lookup.
// Latency: n/a (package).
// Backpressure: n/a.
package bbc_kb_pkg;

    localparam int          NUM_COLS = 10;
    localparam logic [7:0]  PS2_EXT  = 8'hE0;
    localparam logic [7:0]  PS2_BRK  = 8'hF0;
    localparam logic [7:0]  PS2_F12  = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK
    } kb_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] col;
        logic [2:0] row;
    } key_map_t;

    // Entries are written as BBC internal key numbers (row in [6:4], column in [3:0]),
    // which is how the BBC key matrix is normally documented.
    function automatic key_map_t map(input logic [7:0] code, input logic ext);
        key_map_t   r;
        logic [7:0] kn;
        logic       h;
        h  = 1'b1;
        kn = 8'h00;
        case ({ext, code})
            9'h012, 9'h059: kn = 8'h00;  // SHIFT (left and right)
            9'h014, 9'h114: kn = 8'h01;  // CTRL (left and right)
            9'h015:         kn = 8'h10;  // Q
            9'h026:         kn = 8'h11;  // 3
            9'h01D:         kn = 8'h21;  // W
            9'h024:         kn = 8'h22;  // E
            9'h016:         kn = 8'h30;  // 1
            9'h01E:         kn = 8'h31;  // 2
            9'h023:         kn = 8'h32;  // D
            9'h058:         kn = 8'h40;  // CAPS LOCK
            9'h01C:         kn = 8'h41;  // A
            9'h022:         kn = 8'h42;  // X
            9'h05A:         kn = 8'h49;  // RETURN
            9'h01B:         kn = 8'h51;  // S
            9'h021:         kn = 8'h52;  // C
            9'h066:         kn = 8'h59;  // DELETE (backspace)
            9'h00D:         kn = 8'h60;  // TAB
            9'h01A:         kn = 8'h61;  // Z
            9'h029:         kn = 8'h62;  // SPACE
            9'h076:         kn = 8'h70;  // ESCAPE
            9'h005:         kn = 8'h71;  // f1
            9'h16B:         kn = 8'h19;  // cursor left
            9'h172:         kn = 8'h29;  // cursor down
            9'h175:         kn = 8'h39;  // cursor up
            9'h174:         kn = 8'h79;  // cursor right
            default:        h  = 1'b0;
        endcase
        r.hit = h;
        r.col = kn[3:0];
        r.row = kn[6:4];
        return r;
    endfunction

endpackage

// File: rtl/bbc_keyboard_fsm.sv
// PS/2 prefix FSM (E0 / F0) turning raw bytes into make/release key events.
// Latency: key_evt is decoded in the same cycle as the final byte, so the matrix updates on that edge.
// Backpressure: none; every byte presented with i_valid is consumed.
module ps2_scancode_fsm
    import bbc_kb_pkg::*;
(
    input  logic       clk,
    input  logic       i_nreset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_key_evt,
    output logic       o_make,
    output logic       o_hit,
    output logic [3:0] o_col,
    output logic [2:0] o_row,
    output logic       o_is_break_key
);

    kb_state_t r_state;
    logic      w_ext;
    logic      w_make;
    logic      w_evt;
    logic      w_ignored;
    key_map_t  w_map;

    assign w_ignored = (i_data == 8'hE1) || (i_data == 8'hAA) || (i_data == 8'hFA) ||
                       (i_data == 8'hFE) || (i_data == 8'hEE);

    // Track the prefix bytes; any completed code returns to IDLE.
    always_ff @(posedge clk) begin
        if (!i_nreset) begin
            r_state <= ST_IDLE;
        end else if (i_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_data == PS2_EXT)      r_state <= ST_EXT;
                    else if (i_data == PS2_BRK) r_state <= ST_BRK;
                end
                ST_EXT:  r_state <= (i_data == PS2_BRK) ? ST_EXTBRK : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Event decode is combinational so the key bit lands on the edge sampling the final byte.
    always_comb begin
        w_ext  = 1'b0;
        w_make = 1'b1;
        w_evt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_evt = i_valid && (i_data != PS2_EXT) && (i_data != PS2_BRK) && !w_ignored;
            end
            ST_EXT: begin
                w_ext = 1'b1;
                w_evt = i_valid && (i_data != PS2_BRK);
            end
            ST_BRK: begin
                w_make = 1'b0;
                w_evt  = i_valid;
            end
            default: begin
                w_ext  = 1'b1;
                w_make = 1'b0;
                w_evt  = i_valid;
            end
        endcase
    end

    assign w_map          = map(i_data, w_ext);
    assign o_key_evt      = w_evt && i_nreset;
    assign o_make         = w_make;
    assign o_hit          = w_map.hit;
    assign o_col          = w_map.col;
    assign o_row          = w_map.row;
    assign o_is_break_key = !w_ext && (i_data == PS2_F12);

endmodule

// File: rtl/bbc_keyboard.sv
// BBC key matrix fed by PS/2 scancodes, read by the system VIA via PA7 (manual) and CA2 (autoscan).
// Latency: matrix bit updates on the final-byte edge; PA7/CA2 are combinational from matrix/scan_col.
// Backpressure: none; every PS/2 byte is consumed.
module bbc_keyboard
    import bbc_kb_pkg::*;
#(
    parameter logic [7:0] LINKS = 8'h00
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       ps2_valid,
    input  logic [7:0] ps2_data,
    input  logic       nKBEN,
    input  logic [3:0] kb_col,
    input  logic [2:0] kb_row,
    output logic       kb_pa7,
    output logic       kb_ca2,
    output logic       nBREAK
);

    logic [NUM_COLS-1:0][7:0] r_key;
    logic [3:0]               r_scan_col;
    logic                     r_nbreak;

    logic       w_evt;
    logic       w_make;
    logic       w_hit;
    logic [3:0] w_col;
    logic [2:0] w_row;
    logic       w_brk_key;
    logic [7:0] w_col_keys;
    logic [3:0] w_link_idx;

    ps2_scancode_fsm u_fsm (
        .clk            (clk),
        .i_nreset       (nRESET),
        .i_valid        (ps2_valid),
        .i_data         (ps2_data),
        .o_key_evt      (w_evt),
        .o_make         (w_make),
        .o_hit          (w_hit),
        .o_col          (w_col),
        .o_row          (w_row),
        .o_is_break_key (w_brk_key)
    );

    // Key matrix: make sets, release clears; repeats of a make are harmless.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_key <= '0;
        end else if (w_evt && w_hit && !w_brk_key && (w_col < 4'(NUM_COLS))) begin
            r_key[w_col][w_row] <= w_make;
        end
    end

    // BREAK lives outside the matrix: it resets the machine rather than being scanned.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_nbreak <= 1'b1;
        end else if (w_evt && w_brk_key) begin
            r_nbreak <= !w_make;
        end
    end

    // Column select: follows the VIA in manual mode, free-runs on the 1 MHz enable otherwise.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_scan_col <= 4'd0;
        end else if (!nKBEN) begin
            r_scan_col <= kb_col;
        end else if (clk_en) begin
            r_scan_col <= r_scan_col + 4'd1;
        end
    end

    assign w_link_idx = r_scan_col - 4'd2;

    // Current column's 8 rows, with the link jumpers merged into row 0; columns 10-15 are empty.
    always_comb begin
        w_col_keys = 8'h00;
        if (r_scan_col < 4'(NUM_COLS)) begin
            w_col_keys = r_key[r_scan_col];
            if (r_scan_col >= 4'd2) begin
                w_col_keys[0] = w_col_keys[0] | LINKS[w_link_idx[2:0]];
            end
        end
    end

    assign kb_pa7 = w_col_keys[kb_row];
    assign kb_ca2 = |w_col_keys[7:1];
    assign nBREAK = r_nbreak;

endmodule

// File: doc/bbc_keyboard.md
# bbc_keyboard

Keyboard matrix emulator for the system VIA. It converts deserialised PS/2 scancode bytes into a 10-column × 8-row BBC key matrix. It then presents that matrix to the VIA in two ways: manual row/column interrogation on PA7, and an autoscan "key pressed" level on CA2. It sits directly upstream of the system MOS6522: it drives PORTA[7] and CA2, and it consumes PORTA[6:0] and the addressable-latch keyboard-enable bit.

## Interface
- LINKS, 8'h00: startup link state. Bit n appears as row 0, column n+2 (columns 2–9). 1 = link made, reads as pressed.
- clk  in  1  system clock.
- nRESET  in  1  reset; synchronous, active-low.
- clk_en  in  1  1 MHz enable; the autoscan counter advances only on it.
- ps2_valid  in  1  one-cycle strobe: ps2_data holds a complete received byte.
- ps2_data  in  8  PS/2 set-2 scancode byte.
- nKBEN  in  1  keyboard enable (latch bit 3). 0 = manual, 1 = autoscan.
- kb_col  in  4  column select (VIA PA[3:0]).
- kb_row  in  3  row select (VIA PA[6:4]).
- kb_pa7  out  1  selected key pressed; drives VIA PA7.
- kb_ca2  out  1  any row 1–7 key pressed in the current column; drives VIA CA2.
- nBREAK  out  1  low while BREAK (PS/2 F12, 0x07) is held.

## Operation
- Matrix: 80 bits key[col][row], 1 = pressed.
  - Reset clears every key bit.
  - LINKS bits are constant and are ORed into row 0, columns 2–9; they are not stored.
- Scancode FSM states:
  - IDLE: byte E0 → EXT; F0 → BRK; any other byte → apply make(code, ext=0).
  - EXT: F0 → EXTBRK; any other byte → apply make(code, ext=1), then go to IDLE.
  - BRK: any byte → apply release(code, ext=0), then go to IDLE.
  - EXTBRK: any byte → apply release(code, ext=1), then go to IDLE.
  - Bytes E1, AA, FA, FE and EE in IDLE are ignored; the FSM stays in IDLE.
- Mapping:
  - Package function map(code, ext) returns {hit, col[3:0], row[2:0]}.
  - hit = 0 means the key is ignored and the matrix is unchanged.
  - Make sets the bit; release clears it. Typematic repeats of a make byte are idempotent.
  - F12 (ext = 0) does not map into the matrix. Make drives nBREAK low; release drives it high.
  - Both PS/2 shifts (0x12, 0x59) map to the same BBC SHIFT key at col 0, row 0. Releasing either shift clears it.
- Column counter: 4-bit, named scan_col.
  - nKBEN = 0: scan_col <= kb_col every clk (manual mode).
  - nKBEN = 1: scan_col increments on clk_en and wraps 15 → 0.
- kb_pa7 = key[scan_col][kb_row], with LINKS included.
  - Columns 10–15 read 0.
- kb_ca2 = OR of key[scan_col][7:1]. Row 0 (shift, ctrl, links) never raises CA2.
  - Columns 10–15 give 0.
  - kb_ca2 is a level; the VIA does the edge detection.
- Boundary cases:
  - A matrix update and a read in the same cycle: the read returns the old value. The new value is visible the next cycle.
  - kb_col ≥ 10 in manual mode: kb_pa7 = 0.
  - Reset in any FSM state: FSM returns to IDLE and the prefix is discarded.
  - ps2_valid high on consecutive cycles: each byte is consumed. There is no back-pressure.

## Timing
- Reset values:
  - Outputs: kb_pa7 = 0 (or the LINKS value when row 0 and columns 2–9 are selected); kb_ca2 = 0; nBREAK = 1.
  - Internal: scan_col = 0; FSM = IDLE.
- Scancode-to-matrix latency: the bit updates at the clk edge that samples the final byte with ps2_valid = 1. kb_pa7 and kb_ca2 reflect it one cycle later.
- kb_pa7 and kb_ca2 are combinational from the matrix, scan_col and kb_row. There are no extra pipeline stages.
- Manual mode: kb_pa7 follows a kb_col change after one clk, because scan_col is registered. A kb_row change takes effect combinationally.
- Autoscan: each column is held for exactly one clk_en period. A full sweep takes 16 clk_en.
- Mode switch: scan_col keeps its value when switching to autoscan and counts on from it.

## Structure
- Package bbc_kb_pkg holds:
  - constants NUM_COLS = 10, PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_F12 = 8'h07;
  - an FSM state enum;
  - the map() function, a case-statement lookup table.
- Sub-module ps2_scancode_fsm contains the prefix FSM. It outputs a one-cycle key_evt strobe plus {make, hit, col, row, is_break_key}.
- The top level holds the matrix, the column counter and the output logic.

## Test plan
- Press and release 'A': bytes 1C, then F0 1C, with nKBEN = 0, kb_col = 1, kb_row = 4.
  - kb_pa7 = 1 one cycle after 1C; kb_pa7 = 0 one cycle after the second 1C.
- Autoscan with a key held: hold space (0x29 → col 2, row 6), nKBEN = 1.
  - kb_ca2 = 1 only while scan_col = 2, once every 16 clk_en.
- Shift does not raise CA2: hold left shift (0x12) in autoscan.
  - kb_ca2 stays 0 throughout.
  - In manual mode with col 0, row 0: kb_pa7 = 1.
- Links, break and out-of-range columns: LINKS = 8'h81.
  - col 2, row 0 reads 1; col 9, row 0 reads 1; col 5, row 0 reads 0; kb_col = 12 reads 0.
  - Bytes 07, then F0 07: nBREAK goes low, then high, and the matrix is unchanged.
- Extended codes and unmapped codes:
  - E0 75 (up arrow) sets the mapped bit; E0 F0 75 clears it.
  - An unmapped byte, e.g. 0x00, leaves the matrix unchanged.
- Reset mid-sequence: feed F0, assert nRESET = 0 for one cycle, then feed 1C.
  - 'A' is pressed, because the prefix was discarded.
  - Every other matrix bit and scan_col are 0.
